// File: rtl/soc_rst_seq_if.sv
// rtl/soc_rst_seq_if.sv - core-side control bundle between the reset sequencer and core_region
interface soc_rst_seq_if;
    logic        fetch_enable_i;
    logic [31:0] boot_addr_i;
    logic        core_busy_i;
    logic        soft_rst_req_i;
    logic        fetch_enable_o;
    logic [31:0] boot_addr_o;

    // SoC side: drives requests and status, receives the gated controls
    modport master (
        output fetch_enable_i,
        output boot_addr_i,
        output core_busy_i,
        output soft_rst_req_i,
        input  fetch_enable_o,
        input  boot_addr_o
    );

    // Sequencer side
    modport slave (
        input  fetch_enable_i,
        input  boot_addr_i,
        input  core_busy_i,
        input  soft_rst_req_i,
        output fetch_enable_o,
        output boot_addr_o
    );
endinterface

// File: rtl/soc_rst_seq.sv
// rtl/soc_rst_seq.sv - staged peripheral/core reset and boot sequencer
module soc_rst_seq #(
    parameter int LOCK_TIMEOUT      = 1024,
    parameter int PERIPH_RST_CYCLES = 16,
    parameter int CORE_RST_CYCLES   = 8,
    parameter int DRAIN_TIMEOUT     = 256,
    parameter int CNT_WIDTH         = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             testmode_i,
    input  logic             fll_lock_i,
    soc_rst_seq_if.slave     core_if,
    output logic             periph_rstn_o,
    output logic             core_rstn_o,
    output logic [2:0]       state_o,
    output logic [1:0]       status_o
);

    typedef enum logic [2:0] {
        WAIT_LOCK   = 3'd0,
        PERIPH_HOLD = 3'd1,
        CORE_HOLD   = 3'd2,
        WAIT_FETCH  = 3'd3,
        RUN         = 3'd4,
        SOFT_DRAIN  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] PERIPH_LOAD = CNT_WIDTH'(PERIPH_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CORE_LOAD   = CNT_WIDTH'(CORE_RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST  = CNT_WIDTH'(DRAIN_TIMEOUT - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 lock_meta;
    logic                 lock_s;
    logic                 lock_d;
    logic                 periph_rstn_r;
    logic                 core_rstn_r;
    logic                 fetch_en_r;
    logic [31:0]          boot_addr_r;
    logic [1:0]           status_r;

    // Lock synchroniser plus the sequencing FSM; one shared counter serves every timed state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            lock_d        <= 1'b0;
            periph_rstn_r <= 1'b0;
            core_rstn_r   <= 1'b0;
            fetch_en_r    <= 1'b0;
            boot_addr_r   <= '0;
            status_r      <= '0;
        end else begin
            lock_meta <= fll_lock_i;
            lock_s    <= lock_meta;
            lock_d    <= lock_s;
            case (state)
                WAIT_LOCK: begin
                    cnt <= cnt + CNT_ONE;
                    // lock takes priority so a late lock never flags a timeout
                    if (lock_s) begin
                        state <= PERIPH_HOLD;
                        cnt   <= PERIPH_LOAD;
                    end else if (cnt == LOCK_LAST) begin
                        state       <= PERIPH_HOLD;
                        cnt         <= PERIPH_LOAD;
                        status_r[0] <= 1'b1;
                    end
                end
                PERIPH_HOLD: begin
                    if (cnt == '0) begin
                        periph_rstn_r <= 1'b1;
                        state         <= CORE_HOLD;
                        cnt           <= CORE_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                CORE_HOLD: begin
                    fetch_en_r <= 1'b0;
                    // boot address is captured on the very edge the core leaves reset
                    if (cnt == '0) begin
                        core_rstn_r <= 1'b1;
                        boot_addr_r <= core_if.boot_addr_i;
                        state       <= WAIT_FETCH;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WAIT_FETCH: begin
                    if (core_if.fetch_enable_i) begin
                        state      <= RUN;
                        fetch_en_r <= 1'b1;
                    end
                end
                RUN: begin
                    fetch_en_r <= core_if.fetch_enable_i;
                    // lock loss is only recorded; the running system is left alone
                    if (lock_d && !lock_s) begin
                        status_r[1] <= 1'b1;
                    end
                    if (core_if.soft_rst_req_i) begin
                        state      <= SOFT_DRAIN;
                        fetch_en_r <= 1'b0;
                        cnt        <= '0;
                    end
                end
                SOFT_DRAIN: begin
                    fetch_en_r <= 1'b0;
                    cnt        <= cnt + CNT_ONE;
                    if (!core_if.core_busy_i || cnt == DRAIN_LAST) begin
                        state       <= CORE_HOLD;
                        core_rstn_r <= 1'b0;
                        cnt         <= CORE_LOAD;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Scan/test bypass: resets follow the pin directly, fetch and boot pass straight through
    assign periph_rstn_o          = testmode_i ? rst_n : periph_rstn_r;
    assign core_rstn_o            = testmode_i ? rst_n : core_rstn_r;
    assign core_if.fetch_enable_o = testmode_i ? core_if.fetch_enable_i : fetch_en_r;
    assign core_if.boot_addr_o    = testmode_i ? core_if.boot_addr_i : boot_addr_r;
    assign state_o                = state;
    assign status_o               = status_r;

endmodule

// File: tb/tb_soc_rst_seq.sv
// tb/tb_soc_rst_seq.sv - self-checking bench for soc_rst_seq
module tb_soc_rst_seq;
    localparam int LOCK_TIMEOUT = 1024;
    localparam int PERIPH_CYC   = 16;
    localparam int CORE_CYC     = 8;
    localparam int DRAIN_CYC    = 256;
    localparam int SYNC_LAT     = 2;
    // lock seen by FSM one edge after lock_s, then PERIPH_CYC cycles of hold
    localparam int LOCK_TO_PERIPH = SYNC_LAT + 1 + PERIPH_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        testmode = 1'b0;
    logic        fll_lock = 1'b0;
    logic        periph_rstn_o;
    logic        core_rstn_o;
    logic [2:0]  state_o;
    logic [1:0]  status_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [31:0] boot_exp;

    soc_rst_seq_if core_if ();

    soc_rst_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .testmode_i    (testmode),
        .fll_lock_i    (fll_lock),
        .core_if       (core_if),
        .periph_rstn_o (periph_rstn_o),
        .core_rstn_o   (core_rstn_o),
        .state_o       (state_o),
        .status_o      (status_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && !testmode) begin
            vectors++;
            if ((core_rstn_o && !periph_rstn_o) || (core_if.fetch_enable_o && state_o !== 3'd4)) begin
                miscompares++;
                $display("FAIL invariant: core_rstn=%b periph_rstn=%b fetch=%b state=%0d", core_rstn_o, periph_rstn_o, core_if.fetch_enable_o, state_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        core_if.fetch_enable_i = 1'b0;
        core_if.boot_addr_i = $urandom;
        core_if.core_busy_i = 1'b0;
        core_if.soft_rst_req_i = 1'b0;
        repeat (3) step();
        vectors++;
        if ({periph_rstn_o, core_rstn_o, core_if.fetch_enable_o, state_o, status_o} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 00000000", {periph_rstn_o, core_rstn_o, core_if.fetch_enable_o, state_o, status_o});
        end
        vectors++;
        if (core_if.boot_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_boot: got %h want 00000000", core_if.boot_addr_o);
        end
    endtask

    task automatic test_powerup();
        int k, p, d;
        logic [31:0] a;
        a = $urandom;
        core_if.boot_addr_i = a;
        fll_lock = 1'b0;
        rst_n = 1'b1;
        d = $urandom_range(3, 40);
        repeat (d) step();
        fll_lock = 1'b1;
        k = cyc;
        for (int i = 0; i < 100 && periph_rstn_o !== 1'b1; i++) step();
        vectors++;
        if (cyc - k !== LOCK_TO_PERIPH || state_o !== 3'd2) begin
            miscompares++;
            $display("FAIL powerup_periph: latency %0d state %0d want %0d state 2", cyc - k, state_o, LOCK_TO_PERIPH);
        end
        p = cyc;
        for (int i = 0; i < 50 && core_rstn_o !== 1'b1; i++) step();
        vectors++;
        if (cyc - p !== CORE_CYC || state_o !== 3'd3) begin
            miscompares++;
            $display("FAIL powerup_core: delay %0d state %0d want %0d state 3", cyc - p, state_o, CORE_CYC);
        end
        vectors++;
        if (core_if.boot_addr_o !== a || status_o !== 2'b00 || core_if.fetch_enable_o !== 1'b0) begin
            miscompares++;
            $display("FAIL powerup_boot: boot %h status %b fetch %b want %h 00 0", core_if.boot_addr_o, status_o, core_if.fetch_enable_o, a);
        end
        boot_exp = a;
    endtask

    task automatic test_boot_fetch();
        logic x;
        logic [31:0] b;
        b = boot_exp ^ 32'h1A00_0000 ^ $urandom;
        if (b == boot_exp) b = ~boot_exp;
        core_if.boot_addr_i = b;
        repeat ($urandom_range(2, 10)) step();
        vectors++;
        if (core_if.boot_addr_o !== boot_exp || core_if.fetch_enable_o !== 1'b0 || state_o !== 3'd3) begin
            miscompares++;
            $display("FAIL boot_hold: boot %h fetch %b state %0d want %h 0 3", core_if.boot_addr_o, core_if.fetch_enable_o, state_o, boot_exp);
        end
        core_if.fetch_enable_i = 1'b1;
        step();
        vectors++;
        if (core_if.fetch_enable_o !== 1'b1 || state_o !== 3'd4) begin
            miscompares++;
            $display("FAIL fetch_start: fetch %b state %0d want 1 4", core_if.fetch_enable_o, state_o);
        end
        for (int i = 0; i < 20; i++) begin
            x = 1'($urandom_range(0, 1));
            core_if.fetch_enable_i = x;
            core_if.boot_addr_i = $urandom;
            step();
            vectors++;
            if (core_if.fetch_enable_o !== x || core_if.boot_addr_o !== boot_exp) begin
                miscompares++;
                $display("FAIL run_follow: fetch %b boot %h want %b %h", core_if.fetch_enable_o, core_if.boot_addr_o, x, boot_exp);
            end
        end
        core_if.fetch_enable_i = 1'b1;
        step();
    endtask

    task automatic test_soft(input logic busy);
        int n, m, exp_len;
        logic periph_low, fetch_seen;
        logic [31:0] c;
        c = $urandom;
        exp_len = busy ? DRAIN_CYC : 1;
        core_if.boot_addr_i = c;
        core_if.core_busy_i = busy;
        core_if.fetch_enable_i = 1'b0;
        core_if.soft_rst_req_i = 1'b1;
        step();
        core_if.soft_rst_req_i = 1'b0;
        vectors++;
        if (state_o !== 3'd5 || core_if.fetch_enable_o !== 1'b0) begin
            miscompares++;
            $display("FAIL soft_enter: state %0d fetch %b want 5 0", state_o, core_if.fetch_enable_o);
        end
        n = 1;
        for (int i = 0; i < 400 && state_o === 3'd5; i++) begin
            core_if.soft_rst_req_i = (i == 2);
            step();
            if (state_o === 3'd5) n++;
        end
        core_if.soft_rst_req_i = 1'b0;
        vectors++;
        if (n !== exp_len || state_o !== 3'd2 || core_rstn_o !== 1'b0) begin
            miscompares++;
            $display("FAIL soft_drain_len: len %0d state %0d core %b want %0d 2 0", n, state_o, core_rstn_o, exp_len);
        end
        m = 0;
        periph_low = 1'b0;
        fetch_seen = 1'b0;
        for (int i = 0; i < 50 && core_rstn_o !== 1'b1; i++) begin
            core_if.soft_rst_req_i = (i == 3);
            step();
            m++;
            if (periph_rstn_o !== 1'b1) periph_low = 1'b1;
            if (core_if.fetch_enable_o !== 1'b0) fetch_seen = 1'b1;
        end
        core_if.soft_rst_req_i = 1'b0;
        vectors++;
        if (m !== CORE_CYC || periph_low || fetch_seen || state_o !== 3'd3) begin
            miscompares++;
            $display("FAIL soft_core_hold: cycles %0d periph_low %b fetch %b state %0d want %0d 0 0 3", m, periph_low, fetch_seen, state_o, CORE_CYC);
        end
        vectors++;
        if (core_if.boot_addr_o !== c) begin
            miscompares++;
            $display("FAIL soft_boot: got %h want %h", core_if.boot_addr_o, c);
        end
        boot_exp = c;
        core_if.fetch_enable_i = 1'b1;
        step();
        vectors++;
        if (state_o !== 3'd4 || core_if.fetch_enable_o !== 1'b1) begin
            miscompares++;
            $display("FAIL soft_rerun: state %0d fetch %b want 4 1", state_o, core_if.fetch_enable_o);
        end
    endtask

    task automatic test_lock_loss();
        fll_lock = 1'b0;
        repeat (SYNC_LAT) step();
        vectors++;
        if (status_o !== 2'b00) begin
            miscompares++;
            $display("FAIL lock_loss_early: status %b want 00", status_o);
        end
        step();
        vectors++;
        if (status_o !== 2'b10 || state_o !== 3'd4 || {periph_rstn_o, core_rstn_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL lock_loss: status %b state %0d rst %b want 10 4 11", status_o, state_o, {periph_rstn_o, core_rstn_o});
        end
        fll_lock = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_no_lock();
        int r, e;
        rst_n = 1'b0;
        fll_lock = 1'b0;
        step();
        rst_n = 1'b1;
        r = cyc;
        for (int i = 0; i < 2000 && state_o === 3'd0; i++) step();
        vectors++;
        if (cyc - r !== LOCK_TIMEOUT || state_o !== 3'd1 || status_o !== 2'b01) begin
            miscompares++;
            $display("FAIL no_lock_timeout: after %0d state %0d status %b want %0d 1 01", cyc - r, state_o, status_o, LOCK_TIMEOUT);
        end
        e = cyc;
        for (int i = 0; i < 100 && periph_rstn_o !== 1'b1; i++) step();
        vectors++;
        if (cyc - e !== PERIPH_CYC) begin
            miscompares++;
            $display("FAIL no_lock_periph: hold %0d want %0d", cyc - e, PERIPH_CYC);
        end
        e = cyc;
        for (int i = 0; i < 50 && core_rstn_o !== 1'b1; i++) step();
        vectors++;
        if (cyc - e !== CORE_CYC || status_o !== 2'b01 || state_o !== 3'd3) begin
            miscompares++;
            $display("FAIL no_lock_core: hold %0d status %b state %0d want %0d 01 3", cyc - e, status_o, state_o, CORE_CYC);
        end
        step();
    endtask

    task automatic test_rst_mid();
        int r, p;
        fll_lock = 1'b1;
        core_if.core_busy_i = 1'b0;
        core_if.fetch_enable_i = 1'b1;
        repeat (3) step();
        core_if.soft_rst_req_i = 1'b1;
        step();
        core_if.soft_rst_req_i = 1'b0;
        repeat (3) step();
        #2;
        vectors++;
        if (state_o !== 3'd2 || periph_rstn_o !== 1'b1 || status_o !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_mid_pre: state %0d periph %b status %b want 2 1 01", state_o, periph_rstn_o, status_o);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({periph_rstn_o, core_rstn_o, state_o, status_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %b want 0000000", {periph_rstn_o, core_rstn_o, state_o, status_o});
        end
        step();
        rst_n = 1'b1;
        r = cyc;
        for (int i = 0; i < 100 && periph_rstn_o !== 1'b1; i++) step();
        vectors++;
        if (cyc - r !== LOCK_TO_PERIPH) begin
            miscompares++;
            $display("FAIL rst_mid_periph: latency %0d want %0d", cyc - r, LOCK_TO_PERIPH);
        end
        p = cyc;
        for (int i = 0; i < 50 && core_rstn_o !== 1'b1; i++) step();
        vectors++;
        if (cyc - p !== CORE_CYC || status_o !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_core: delay %0d status %b want %0d 00", cyc - p, status_o, CORE_CYC);
        end
    endtask

    task automatic test_lock_race();
        int r;
        rst_n = 1'b0;
        fll_lock = 1'b0;
        step();
        rst_n = 1'b1;
        r = cyc;
        repeat (LOCK_TIMEOUT - 1 - SYNC_LAT) step();
        fll_lock = 1'b1;
        for (int i = 0; i < 100 && state_o === 3'd0; i++) step();
        vectors++;
        if (cyc - r !== LOCK_TIMEOUT || status_o !== 2'b00 || state_o !== 3'd1) begin
            miscompares++;
            $display("FAIL lock_race: after %0d status %b state %0d want %0d 00 1", cyc - r, status_o, state_o, LOCK_TIMEOUT);
        end
    endtask

    task automatic test_testmode();
        logic rv, fv;
        logic [31:0] bv;
        testmode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rv = 1'($urandom_range(0, 1));
            fv = 1'($urandom_range(0, 1));
            bv = $urandom;
            #3;
            rst_n = rv;
            core_if.fetch_enable_i = fv;
            core_if.boot_addr_i = bv;
            #1;
            vectors++;
            if ({periph_rstn_o, core_rstn_o, core_if.fetch_enable_o} !== {rv, rv, fv} || core_if.boot_addr_o !== bv) begin
                miscompares++;
                $display("FAIL testmode_bypass: rst %b fetch %b boot %h want %b %b %h", {periph_rstn_o, core_rstn_o}, core_if.fetch_enable_o, core_if.boot_addr_o, {rv, rv}, fv, bv);
            end
        end
        rst_n = 1'b0;
        fll_lock = 1'b1;
        core_if.fetch_enable_i = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100 && state_o !== 3'd4; i++) step();
        repeat (2) step();
        fll_lock = 1'b0;
        repeat (SYNC_LAT + 2) step();
        vectors++;
        if (status_o !== 2'b10 || state_o !== 3'd4) begin
            miscompares++;
            $display("FAIL testmode_lock_loss: status %b state %0d want 10 4", status_o, state_o);
        end
        testmode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_boot_fetch();
        test_soft(1'b1);
        test_soft(1'b0);
        test_lock_loss();
        test_no_lock();
        test_rst_mid();
        test_lock_race();
        test_testmode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
